// File: rtl/serial_add_sub_ctrl.sv
//------------------------------------------------------------------------------
// serial_add_sub_ctrl : bit-serial WIDTH-bit add/sub with start/busy/done control
// Optional feature macro: OVERFLOW_DETECT_EN (adds registered signed-overflow ovf)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             SU,
  input  logic             EO,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef OVERFLOW_DETECT_EN
  output logic             ovf,
`endif
  output logic             Cout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
`ifdef OVERFLOW_DETECT_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_s;
  logic bit_c;

  // One full-adder slice shared by every bit position.
  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    res_d    = res_q;
    cout_d   = cout_q;
`ifdef OVERFLOW_DETECT_EN
    ovf_d    = ovf_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with SU.
          a_sr_d  = in1;
          b_sr_d  = SU ? ~in2 : in2;
          carry_d = SU;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy     = 1'b1;
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {bit_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = bit_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          res_d   = {bit_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = bit_c;
`ifdef OVERFLOW_DETECT_EN
          // carry_q here is the carry into the MSB slice.
          ovf_d   = carry_q ^ bit_c;
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
`ifdef OVERFLOW_DETECT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result = EO ? res_q : '0;
  assign Cout   = cout_q;
`ifdef OVERFLOW_DETECT_EN
  assign ovf    = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_add_sub_ctrl : scoreboard bench with an arithmetic reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_sub_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in1, in2;
  logic         SU, EO;
  logic         busy, done, Cout;
  logic [W-1:0] result;
`ifdef OVERFLOW_DETECT_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  exp_t last_exp;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .SU     (SU),
    .EO     (EO),
    .busy   (busy),
    .done   (done),
    .result (result),
`ifdef OVERFLOW_DETECT_EN
    .ovf    (ovf),
`endif
    .Cout   (Cout)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endfunction

  // Reference: plain modular arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit su);
    exp_t         e;
    logic [W:0]   full;
    if (su) begin
      full   = {1'b0, a} - {1'b0, b};
      e.cout = (a >= b);
      e.res  = full[W-1:0];
      e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b};
      e.cout = full[W];
      e.res  = full[W-1:0];
      e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    end
    return e;
  endfunction

  // Monitor: pops one expectation per done and checks the held outputs every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_exp = '0;
    end else begin
      if (done) begin
        check("done_expected", exp_q.size() != 0, 1);
        check("busy_in_done", busy, 1);
        if (exp_q.size() != 0) last_exp = exp_q.pop_front();
      end
      check("result", result, EO ? last_exp.res : '0);
      check("cout", Cout, last_exp.cout);
`ifdef OVERFLOW_DETECT_EN
      check("ovf", ovf, last_exp.ovf);
`endif
    end
  end

  task automatic cycle_drive(input bit st, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit su, input bit eo);
    bit idle;
    start = st; in1 = a; in2 = b; SU = su; EO = eo;
    idle  = !busy && rst_n;
    @(posedge clk);
    if (st && idle) exp_q.push_back(model(a, b, su));
    #1;
  endtask

  task automatic noise(input int n, input bit eo);
    for (int i = 0; i < n; i++)
      cycle_drive(($urandom_range(0, 1) == 1), W'($urandom), W'($urandom), $urandom_range(0, 1) == 1, eo);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      cycle_drive(1'b0, W'($urandom), W'($urandom), 1'b0, 1'b1);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  // Directed operation with expectations taken from fixed constants.
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input bit su,
                          input bit eo, input logic [W-1:0] res, input bit cout);
    exp_t e;
    wait_idle();
    start = 1'b1; in1 = a; in2 = b; SU = su; EO = 1'b1;
    @(posedge clk);
    e      = model(a, b, su);
    e.res  = res;
    e.cout = cout;
    exp_q.push_back(e);
    #1;
    start = 1'b0;
    // Start retoggled and operands scrambled while busy must not matter.
    noise(W + 1, eo);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0; SU = 1'b0; EO = 1'b1;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", Cout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed(8'h3C, 8'h25, 1'b0, 1'b1, 8'h61, 1'b0);
    directed(8'hF0, 8'h20, 1'b0, 1'b1, 8'h10, 1'b1);
    directed(8'h50, 8'h20, 1'b1, 1'b1, 8'h30, 1'b1);
    directed(8'h20, 8'h50, 1'b1, 1'b1, 8'hD0, 1'b0);
    directed(8'h70, 8'h20, 1'b0, 1'b1, 8'h90, 1'b0);
    directed(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1);
    directed(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    directed(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);
    directed(8'hF0, 8'h20, 1'b0, 1'b1, 8'h10, 1'b1);

    // Abort mid-SHIFT: outputs clear at once and no done follows.
    wait_idle();
    start = 1'b1; in1 = 8'h12; in2 = 8'h34; SU = 1'b0; EO = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    noise(3, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", Cout, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    noise(W + 3, 1'b1);

    // Start held high: one done per accepted start, back-to-back.
    for (int i = 0; i < 40; i++) cycle_drive(1'b1, 8'hC8, 8'h64, 1'b1, i[0]);
    for (int i = 0; i < 40; i++) cycle_drive(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1);

    for (int i = 0; i < 1500; i++)
      cycle_drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++)
      cycle_drive(1'b0, '0, '0, 1'b0, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
